// File: rtl/div_sequencer.sv
// Valid/ready sequencer around an external 32-bit combinational unsigned divider:
// converts signed operands to magnitudes, waits a fixed settle window, then sign-corrects the result.
module div_sequencer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_signed,
    input  logic [31:0] in_dividend,
    input  logic [31:0] in_divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_quotient,
    output logic [31:0] out_remainder,
    output logic        out_div_by_zero,
    output logic        busy,
    output logic [31:0] udiv_dividend,
    output logic [31:0] udiv_divisor,
    input  logic [31:0] udiv_quotient,
    input  logic [31:0] udiv_remainder
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        neg_quot_q;
    logic        neg_rem_q;
    logic        out_valid_q;
    logic        out_dbz_q;
    logic [31:0] out_quot_q;
    logic [31:0] out_rem_q;
    logic [31:0] udiv_dvd_q;
    logic [31:0] udiv_dvs_q;

    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] quot_d;
    logic [31:0] rem_d;
    logic        accept;

    assign accept = in_valid && (state_q == IDLE);

    always_comb begin
        dvd_mag = (in_signed && in_dividend[31]) ? (~in_dividend + 32'd1) : in_dividend;
        dvs_mag = (in_signed && in_divisor[31])  ? (~in_divisor + 32'd1)  : in_divisor;
        // Sign correction of the unsigned divider result, modulo 2^32.
        quot_d  = neg_quot_q ? (~udiv_quotient + 32'd1)  : udiv_quotient;
        rem_d   = neg_rem_q  ? (~udiv_remainder + 32'd1) : udiv_remainder;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_dbz_q   <= 1'b0;
            out_quot_q  <= 32'd0;
            out_rem_q   <= 32'd0;
            udiv_dvd_q  <= 32'd0;
            udiv_dvs_q  <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        neg_quot_q <= in_signed && (in_dividend[31] ^ in_divisor[31]);
                        neg_rem_q  <= in_signed && in_dividend[31];
                        if (in_divisor == 32'd0) begin
                            // Divide-by-zero resolves locally; the divider inputs are left alone.
                            out_quot_q  <= 32'hFFFF_FFFF;
                            out_rem_q   <= in_dividend;
                            out_dbz_q   <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            udiv_dvd_q <= dvd_mag;
                            udiv_dvs_q <= dvs_mag;
                            cnt_q      <= CNT_LOAD;
                            state_q    <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        out_quot_q  <= quot_d;
                        out_rem_q   <= rem_d;
                        out_dbz_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready        = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign out_valid       = out_valid_q;
    assign out_quotient    = out_quot_q;
    assign out_remainder   = out_rem_q;
    assign out_div_by_zero = out_dbz_q;
    assign udiv_dividend   = udiv_dvd_q;
    assign udiv_divisor    = udiv_dvs_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer with a behavioural model of the unsigned divider.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_signed = 1'b0;
    logic [31:0] in_dividend = 32'd0;
    logic [31:0] in_divisor = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_quotient;
    logic [31:0] out_remainder;
    logic        out_div_by_zero;
    logic        busy;
    logic [31:0] udiv_dividend;
    logic [31:0] udiv_divisor;
    logic [31:0] udiv_quotient;
    logic [31:0] udiv_remainder;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Combinational unsigned divider stand-in.
    assign udiv_quotient  = (udiv_divisor == 32'd0) ? 32'hFFFF_FFFF : udiv_dividend / udiv_divisor;
    assign udiv_remainder = (udiv_divisor == 32'd0) ? udiv_dividend : udiv_dividend % udiv_divisor;

    div_sequencer #(.SETTLE_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_signed(in_signed),
        .in_dividend(in_dividend),
        .in_divisor(in_divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_quotient(out_quotient),
        .out_remainder(out_remainder),
        .out_div_by_zero(out_div_by_zero),
        .busy(busy),
        .udiv_dividend(udiv_dividend),
        .udiv_divisor(udiv_divisor),
        .udiv_quotient(udiv_quotient),
        .udiv_remainder(udiv_remainder)
    );

    // Present one request; returns after the accept edge.
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_signed   = s;
        in_dividend = a;
        in_divisor  = b;
        in_valid    = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts cycles after the accept edge until out_valid; lat=-1 on timeout.
    task automatic wait_valid(output int lat, output logic [31:0] ud1);
        lat = -1;
        ud1 = 32'hDEAD_BEEF;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) ud1 = udiv_dividend;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_quotient !== 32'd0 || out_remainder !== 32'd0 || out_div_by_zero !== 1'b0)
            begin bad++; $display("FAIL reset_results got q=%h r=%h dbz=%b want 0/0/0", out_quotient, out_remainder, out_div_by_zero); end
        total++; if (udiv_dividend !== 32'd0 || udiv_divisor !== 32'd0)
            begin bad++; $display("FAIL reset_udiv got=%h/%h want=0/0", udiv_dividend, udiv_divisor); end
        $display("reset: in_ready=%b busy=%b out_valid=%b", in_ready, busy, out_valid);
    endtask

    task automatic test_unsigned();
        int lat; logic [31:0] ud1;
        issue(1'b0, 32'd100, 32'd7);
        wait_valid(lat, ud1);
        total++; if (ud1 !== 32'd100) begin bad++; $display("FAIL unsigned_udiv got=%h want=%h", ud1, 32'd100); end
        total++; if (lat !== 5) begin bad++; $display("FAIL unsigned_latency got=%0d want=5", lat); end
        total++; if (out_quotient !== 32'd14 || out_remainder !== 32'd2 || out_div_by_zero !== 1'b0)
            begin bad++; $display("FAIL unsigned_result got q=%h r=%h dbz=%b want 14/2/0", out_quotient, out_remainder, out_div_by_zero); end
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL unsigned_done_flags got busy=%b in_ready=%b want 1/0", busy, in_ready); end
        handshake();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL unsigned_release got valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        $display("unsigned 100/7: lat=%0d q=%0d r=%0d", lat, out_quotient, out_remainder);
    endtask

    task automatic test_signed();
        int lat; logic [31:0] ud1;
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_valid(lat, ud1);
        total++; if (ud1 !== 32'd7) begin bad++; $display("FAIL signed_neg_mag got=%h want=7", ud1); end
        total++; if (lat !== 5) begin bad++; $display("FAIL signed_neg_latency got=%0d want=5", lat); end
        total++; if (out_quotient !== 32'hFFFF_FFFD || out_remainder !== 32'hFFFF_FFFF)
            begin bad++; $display("FAIL signed_neg_result got q=%h r=%h want fffffffd/ffffffff", out_quotient, out_remainder); end
        $display("signed -7/2: q=%h r=%h", out_quotient, out_remainder);
        handshake();
        issue(1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_valid(lat, ud1);
        total++; if (udiv_divisor !== 32'd2) begin bad++; $display("FAIL signed_div_mag got=%h want=2", udiv_divisor); end
        total++; if (out_quotient !== 32'hFFFF_FFFD || out_remainder !== 32'd1 || out_div_by_zero !== 1'b0)
            begin bad++; $display("FAIL signed_divneg_result got q=%h r=%h dbz=%b want fffffffd/1/0", out_quotient, out_remainder, out_div_by_zero); end
        $display("signed 7/-2: q=%h r=%h", out_quotient, out_remainder);
        handshake();
    endtask

    task automatic test_div_zero();
        int lat; logic [31:0] ud1;
        issue(1'b0, 32'h1234_5678, 32'd0);
        wait_valid(lat, ud1);
        total++; if (lat !== 1) begin bad++; $display("FAIL dbz_latency got=%0d want=1", lat); end
        total++; if (out_quotient !== 32'hFFFF_FFFF || out_remainder !== 32'h1234_5678 || out_div_by_zero !== 1'b1)
            begin bad++; $display("FAIL dbz_unsigned got q=%h r=%h dbz=%b want ffffffff/12345678/1", out_quotient, out_remainder, out_div_by_zero); end
        // Previous request left magnitudes 7 and 2 on the divider inputs.
        total++; if (udiv_dividend !== 32'd7 || udiv_divisor !== 32'd2)
            begin bad++; $display("FAIL dbz_udiv_held got=%h/%h want=7/2", udiv_dividend, udiv_divisor); end
        $display("dbz 12345678/0: lat=%0d q=%h r=%h", lat, out_quotient, out_remainder);
        handshake();
        issue(1'b1, 32'h8000_0000, 32'd0);
        wait_valid(lat, ud1);
        total++; if (lat !== 1 || out_quotient !== 32'hFFFF_FFFF || out_remainder !== 32'h8000_0000 || out_div_by_zero !== 1'b1)
            begin bad++; $display("FAIL dbz_signed got lat=%0d q=%h r=%h dbz=%b want 1/ffffffff/80000000/1", lat, out_quotient, out_remainder, out_div_by_zero); end
        $display("dbz signed 80000000/0: q=%h r=%h", out_quotient, out_remainder);
        handshake();
    endtask

    task automatic test_overflow();
        int lat; logic [31:0] ud1;
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_valid(lat, ud1);
        total++; if (ud1 !== 32'h8000_0000 || udiv_divisor !== 32'd1)
            begin bad++; $display("FAIL ovf_mag got=%h/%h want=80000000/1", ud1, udiv_divisor); end
        total++; if (lat !== 5 || out_quotient !== 32'h8000_0000 || out_remainder !== 32'd0 || out_div_by_zero !== 1'b0)
            begin bad++; $display("FAIL ovf_result got lat=%0d q=%h r=%h dbz=%b want 5/80000000/0/0", lat, out_quotient, out_remainder, out_div_by_zero); end
        $display("overflow 80000000/ffffffff: q=%h r=%h", out_quotient, out_remainder);
        handshake();
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] ud1;
        int stray;
        issue(1'b0, 32'd50, 32'd5);
        wait_valid(lat, ud1);
        for (int k = 0; k < 3; k++) begin
            in_signed   = 1'b0;
            in_dividend = 32'd9;
            in_divisor  = 32'd3;
            in_valid    = 1'b1;
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_quotient !== 32'd10 || out_remainder !== 32'd0)
                begin bad++; $display("FAIL bp_hold%0d got valid=%b in_ready=%b q=%h r=%h want 1/0/a/0", k, out_valid, in_ready, out_quotient, out_remainder); end
        end
        in_valid = 1'b0;
        handshake();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin bad++; $display("FAIL bp_release got valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid || busy) stray++;
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL bp_not_queued got=%0d busy/valid cycles want=0", stray); end
        $display("backpressure 50/5: q=%0d held 3 cycles, second request dropped", out_quotient);
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] ud1;
        int stray;
        issue(1'b0, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || busy !== 1'b0 || udiv_dividend !== 32'd0 || udiv_divisor !== 32'd0)
            begin bad++; $display("FAIL midreset_state got in_ready=%b busy=%b udiv=%h/%h want 1/0/0/0", in_ready, busy, udiv_dividend, udiv_divisor); end
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) stray++;
            @(negedge clk);
        end
        total++; if (stray !== 0) begin bad++; $display("FAIL midreset_no_valid got=%0d valid cycles want=0", stray); end
        issue(1'b0, 32'd9, 32'd3);
        wait_valid(lat, ud1);
        total++; if (lat !== 5 || out_quotient !== 32'd3 || out_remainder !== 32'd0)
            begin bad++; $display("FAIL midreset_fresh got lat=%0d q=%h r=%h want 5/3/0", lat, out_quotient, out_remainder); end
        $display("mid-op reset then 9/3: q=%0d r=%0d", out_quotient, out_remainder);
        handshake();
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] ud1;
        issue(1'b0, 32'd1000, 32'd33);
        wait_valid(lat, ud1);
        handshake();
        issue(1'b1, 32'hFFFF_FC18, 32'd33);
        wait_valid(lat, ud1);
        total++; if (lat !== 5 || out_quotient !== 32'hFFFF_FFE2 || out_remainder !== 32'hFFFF_FFF6)
            begin bad++; $display("FAIL b2b_result got lat=%0d q=%h r=%h want 5/ffffffe2/fffffff6", lat, out_quotient, out_remainder); end
        $display("back-to-back -1000/33: q=%h r=%h", out_quotient, out_remainder);
        handshake();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Sequencing front end for the 32-bit combinational unsigned array divider. It accepts signed or unsigned divide requests over a valid/ready handshake, converts the operands to magnitudes, and drives them into the divider. It holds the operands stable for a fixed multicycle settle window, then captures the quotient and remainder, applies sign correction and presents the result downstream over a second valid/ready handshake. Divide-by-zero is resolved locally and never waits on the divider.

## Interface
- `SETTLE_CYCLES`, default 4: cycles the divider operands are held before its outputs are sampled. Legal range 1..255. The divider's timing constraint is a SETTLE_CYCLES multicycle path.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request; high exactly in IDLE.
- `in_signed`  in  1  1 = two's-complement divide, 0 = unsigned.
- `in_dividend`  in  32  dividend.
- `in_divisor`  in  32  divisor.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_quotient`  out  32  final quotient.
- `out_remainder`  out  32  final remainder.
- `out_div_by_zero`  out  1  divisor was zero.
- `busy`  out  1  state is not IDLE.
- `udiv_dividend`  out  32  registered magnitude fed to the divider's Dividend input.
- `udiv_divisor`  out  32  registered magnitude fed to the divider's Divisor input.
- `udiv_quotient`  in  32  the divider's Quotient output.
- `udiv_remainder`  in  32  the divider's Remainder output.

## Operation
- **States:** IDLE, SETTLE, DONE. All outputs except `in_ready` and `busy` are registered. `in_ready` and `busy` decode directly from the state.
- **Reset values:** state IDLE, so `in_ready`=1 and `busy`=0. `out_valid`=0, `out_quotient`=0, `out_remainder`=0, `out_div_by_zero`=0, `udiv_dividend`=0, `udiv_divisor`=0, settle counter=0.
- **IDLE, accept:** on `in_valid & in_ready` the block latches the following:
  - `neg_q` = `in_signed` & (dividend[31] ^ divisor[31]).
  - `neg_r` = `in_signed` & dividend[31].
  - Each operand magnitude: the two's-complement negation when `in_signed` is set and bit 31 is set, otherwise the operand unchanged.
  - The original dividend.
- **Divisor nonzero:** load `udiv_dividend`/`udiv_divisor` with the magnitudes, set counter = SETTLE_CYCLES-1, go to SETTLE.
- **Divisor zero:** go directly to DONE with:
  - `out_quotient` = 0xFFFFFFFF.
  - `out_remainder` = the original dividend, unmodified.
  - `out_div_by_zero` = 1.
  - `udiv_*` unchanged.
- **SETTLE:**
  - `udiv_*` are held constant.
  - While counter ≠ 0, decrement.
  - When counter = 0, capture `out_quotient` = neg_q ? −udiv_quotient : udiv_quotient.
  - Capture `out_remainder` = neg_r ? −udiv_remainder : udiv_remainder.
  - Set `out_div_by_zero` = 0 and go to DONE.
  - All arithmetic is modulo 2^32.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0. No special case is needed; the magnitude path produces this naturally.
- **DONE:**
  - `out_valid`=1 and result registers stable.
  - On `out_ready`=1, clear `out_valid` and return to IDLE.
  - Result registers keep their values until the next capture.
  - Requests presented outside IDLE are ignored, not queued.
- **No overlap:** one request in flight at a time. A new request can be accepted the cycle after the output handshake at the earliest.
- **Reset mid-operation:** `reset` in any state aborts the request. Next cycle is IDLE with reset values, and no `out_valid` is produced for the aborted request.

## Timing
- Accept edge = cycle 0.
- Nonzero divisor: `udiv_*` valid from cycle 1. Results captured at the end of cycle SETTLE_CYCLES. `out_valid` high from cycle SETTLE_CYCLES+1.
- Zero divisor: `out_valid` high from cycle 1.
- Output handshake in cycle N: `out_valid`=0 and `in_ready`=1 in cycle N+1.
- Throughput without backpressure: one result per SETTLE_CYCLES+2 cycles (nonzero divisor).
- `in_ready` is never combinationally dependent on `in_valid` or `out_ready`.

## Test plan
- **Unsigned divide:** SETTLE_CYCLES=4, unsigned 100/7 accepted at cycle 0 -> `udiv_dividend`=100 from cycle 1; `out_valid` first high at cycle 5 with q=14, r=2, dbz=0.
- **Signed divide:** signed 0xFFFFFFF9 (−7) / 2 -> `udiv_dividend`=7; q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7 / 0xFFFFFFFE -> q=0xFFFFFFFD, r=1.
- **Divide by zero:** unsigned 0x12345678/0 -> `out_valid` at cycle 1, q=0xFFFFFFFF, r=0x12345678, dbz=1. Signed 0x80000000/0 -> q=0xFFFFFFFF, r=0x80000000.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, dbz=0.
- **Backpressure:** hold `out_ready`=0 for 3 cycles in DONE and pulse `in_valid` with new operands. `out_valid` and results stay stable, `in_ready`=0, and the second request is not taken. `out_ready`=1 -> IDLE next cycle.
- **Reset mid-operation:** assert `reset` for 1 cycle at cycle 2 of SETTLE -> next cycle IDLE, `udiv_*`=0, `out_valid` stays 0. A fresh 9/3 request completes with q=3, r=0.
